trigger_rs_monitor: RTL and testbench
=====================================

TRIGGER_RS_MONITOR -- requirements
Module: trigger_rs_monitor

Interface
REQ-001 Parameter CNT_W, default 8: width of both event counters.
REQ-002 clk  input  1  sole clock; all sampling and outputs update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 r  input  1  observed reset input of the RS trigger under watch.
REQ-005 s  input  1  observed set input of the RS trigger under watch.
REQ-006 q  input  1  observed registered output of the RS trigger under watch.
REQ-007 clr  input  1  synchronous clear of the counters and the sticky flag.
REQ-008 model_q  output  1  golden expected trigger state.
REQ-009 model_valid  output  1  high when model_q is defined (FSM in TRACK).
REQ-010 err  output  1  one-cycle pulse: the observed q differed from model_q.
REQ-011 forb  output  1  one-cycle pulse: r=s=1 sampled.
REQ-012 err_cnt  output  CNT_W  saturating count of mismatches.
REQ-013 forb_cnt  output  CNT_W  saturating count of forbidden samples.
REQ-014 sticky_err  output  1  set by any mismatch; held until clr or rst.

Function
REQ-015 At every rising clk edge, the block samples r, s and q together; all outputs are registered (1-cycle latency from sample).
REQ-016 The FSM has two states, SYNC and TRACK; model_valid=1 only in TRACK.
REQ-017 SYNC: r=1,s=0 -> model_q<=0, go TRACK; r=0,s=1 -> model_q<=1, go TRACK; r=s=0 -> stay SYNC; r=s=1 -> stay SYNC, forb pulse.
REQ-018 TRACK compare: if sampled q != model_q, then err=1 next cycle, err_cnt+1 and sticky_err<=1; no compare in SYNC.
REQ-019 TRACK update, in the same edge as the compare: r=0,s=0 hold; r=0,s=1 -> 1; r=1,s=0 -> 0; r=s=1 -> forb pulse, go SYNC, model_q holds its last value.
REQ-020 The model evolves from its own state only; it never adopts the observed q, so a diverged trigger yields err every TRACK cycle.
REQ-021 The counters saturate at 2^CNT_W-1 and never wrap.
REQ-022 If clr and an event coincide, clr wins: the counter goes to 0 and sticky_err to 0, but the err/forb pulse still asserts.
REQ-023 clr does not affect the FSM state or model_q.

Reset
REQ-024 On rst: state=SYNC, model_q=0, model_valid=0, err=0, forb=0, err_cnt=0, forb_cnt=0, sticky_err=0; applies immediately, without a clock.
REQ-025 rst mid-operation discards the model; the first clean set/reset after release resynchronises.

Structure
REQ-026 Package trigger_pkg holds the FSM state enum (SYNC, TRACK) and the CNT_W default constant.
REQ-027 One sub-module, sat_counter (CNT_W, inc, clr -> count), is instantiated twice.

Verification
REQ-028 rst pulse, then r=s=0 for 5 cycles -> model_valid=0, err never asserts, counters 0.
REQ-029 s=1 for one cycle with q following 1 cycle later, then r=1 with q->0 -> model_valid=1 after the first edge; err=0 throughout.
REQ-030 In TRACK with model_q=1, force q=0 for 3 cycles (r=s=0) -> err high 3 cycles, err_cnt=3, sticky_err=1.
REQ-031 Drive r=s=1 for 1 cycle in TRACK -> forb pulse, forb_cnt=1, model_valid=0 next cycle; then s=1 -> TRACK, model_q=1.
REQ-032 CNT_W=2, 5 mismatches -> err_cnt=3 (held); clr together with a 6th mismatch -> err_cnt=0, err=1, sticky_err=0.
REQ-033 Assert rst asynchronously mid-cycle while in TRACK with err_cnt=2 -> all outputs 0 before the next edge.

Source files
------------

// File: rtl/trigger_pkg.sv
// Shared types and constants for the RS trigger monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a (no handshakes).
package trigger_pkg;

    // SYNC: model state unknown, wait for a clean set/reset. TRACK: model valid, compare q.
    typedef enum logic {
        SYNC  = 1'b0,
        TRACK = 1'b1
    } state_t;

    localparam int CNT_W_DEFAULT = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
// Latency: count reflects inc/clr one cycle after the sampling edge.
// Backpressure: none; an increment at the ceiling is dropped, never wraps.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Clear first, then increment unless already at the ceiling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/trigger_rs_monitor.sv
// Golden-model monitor for an RS trigger: tracks expected q, flags mismatches and r=s=1 samples.
// Latency: all outputs registered, one cycle after r/s/q are sampled.
// Backpressure: none; observes every cycle, counters saturate instead of wrapping.
module trigger_rs_monitor
    import trigger_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r,
    input  logic             s,
    input  logic             q,
    input  logic             clr,
    output logic             model_q,
    output logic             model_valid,
    output logic             err,
    output logic             forb,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] forb_cnt,
    output logic             sticky_err
);

    state_t state;
    logic   mismatch;
    logic   forb_ev;

    // Compare only once the model is defined; r=s=1 is forbidden in either state.
    assign mismatch    = (state == TRACK) && (q != model_q);
    assign forb_ev     = r & s;
    assign model_valid = (state == TRACK);

    // Model FSM: evolves from its own state only, never adopts the observed q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= SYNC;
            model_q <= 1'b0;
            err     <= 1'b0;
            forb    <= 1'b0;
        end else begin
            err  <= mismatch;
            forb <= forb_ev;
            case (state)
                SYNC: begin
                    if (r && !s) begin
                        model_q <= 1'b0;
                        state   <= TRACK;
                    end else if (!r && s) begin
                        model_q <= 1'b1;
                        state   <= TRACK;
                    end
                end
                TRACK: begin
                    if (r && s) begin
                        // Forbidden input: model_q keeps its last value, resync required.
                        state <= SYNC;
                    end else if (s) begin
                        model_q <= 1'b1;
                    end else if (r) begin
                        model_q <= 1'b0;
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end

    // Sticky mismatch flag; clear beats a coincident mismatch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_err <= 1'b0;
        end else if (clr) begin
            sticky_err <= 1'b0;
        end else if (mismatch) begin
            sticky_err <= 1'b1;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (mismatch),
        .clr   (clr),
        .count (err_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_forb_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (forb_ev),
        .clr   (clr),
        .count (forb_cnt)
    );

endmodule

// File: tb/tb_trigger_rs_monitor.sv
module tb_trigger_rs_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       r = 1'b0;
    logic       s = 1'b0;
    logic       q = 1'b0;
    logic       clr = 1'b0;

    logic       model_q, model_valid, err, forb, sticky_err;
    logic [7:0] err_cnt, forb_cnt;

    logic       n_model_q, n_model_valid, n_err, n_forb, n_sticky_err;
    logic [1:0] n_err_cnt, n_forb_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    trigger_rs_monitor #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .r(r), .s(s), .q(q), .clr(clr),
        .model_q(model_q), .model_valid(model_valid), .err(err), .forb(forb),
        .err_cnt(err_cnt), .forb_cnt(forb_cnt), .sticky_err(sticky_err)
    );

    // Narrow instance sharing the same stimulus, used for the saturation checks.
    trigger_rs_monitor #(.CNT_W(2)) dut_n (
        .clk(clk), .rst(rst), .r(r), .s(s), .q(q), .clr(clr),
        .model_q(n_model_q), .model_valid(n_model_valid), .err(n_err), .forb(n_forb),
        .err_cnt(n_err_cnt), .forb_cnt(n_forb_cnt), .sticky_err(n_sticky_err)
    );

    task automatic drive(input logic rv, input logic sv, input logic qv, input logic cv);
        r = rv; s = sv; q = qv; clr = cv;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        total++; if ({model_q, model_valid, err, forb, sticky_err} !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b exp=00000", {model_q, model_valid, err, forb, sticky_err}); end
        total++; if ({err_cnt, forb_cnt} !== 16'h0) begin bad++; $display("FAIL reset_cnts got=%h exp=0000", {err_cnt, forb_cnt}); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            total++; if (model_valid !== 1'b0) begin bad++; $display("FAIL idle_valid cyc=%0d got=%b exp=0", i, model_valid); end
            total++; if (err !== 1'b0) begin bad++; $display("FAIL idle_err cyc=%0d got=%b exp=0", i, err); end
        end
        total++; if ({err_cnt, forb_cnt} !== 16'h0) begin bad++; $display("FAIL idle_cnts got=%h exp=0000", {err_cnt, forb_cnt}); end
    endtask

    task automatic test_sync_track();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        total++; if ({model_valid, model_q, err} !== 3'b110) begin bad++; $display("FAIL sync_set got=%b exp=110", {model_valid, model_q, err}); end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        total++; if ({model_valid, model_q, err} !== 3'b110) begin bad++; $display("FAIL track_hold1 got=%b exp=110", {model_valid, model_q, err}); end
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        total++; if ({model_valid, model_q, err} !== 3'b100) begin bad++; $display("FAIL track_reset got=%b exp=100", {model_valid, model_q, err}); end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        total++; if ({model_valid, model_q, err} !== 3'b100) begin bad++; $display("FAIL track_hold0 got=%b exp=100", {model_valid, model_q, err}); end
        total++; if (err_cnt !== 8'd0 || sticky_err !== 1'b0) begin bad++; $display("FAIL track_noerr cnt=%0d sticky=%b exp=0/0", err_cnt, sticky_err); end
    endtask

    task automatic test_mismatch();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        total++; if ({model_q, err} !== 2'b10) begin bad++; $display("FAIL mm_setup got=%b exp=10", {model_q, err}); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            total++; if (err !== 1'b1) begin bad++; $display("FAIL mm_err cyc=%0d got=%b exp=1", i, err); end
        end
        total++; if (err_cnt !== 8'd3) begin bad++; $display("FAIL mm_cnt got=%0d exp=3", err_cnt); end
        total++; if (sticky_err !== 1'b1) begin bad++; $display("FAIL mm_sticky got=%b exp=1", sticky_err); end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        total++; if ({err, sticky_err} !== 2'b01 || err_cnt !== 8'd3) begin bad++; $display("FAIL mm_recover err/sticky=%b cnt=%0d exp=01/3", {err, sticky_err}, err_cnt); end
    endtask

    task automatic test_forbidden();
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        total++; if ({forb, model_valid, model_q, err} !== 4'b1010) begin bad++; $display("FAIL forb_track got=%b exp=1010", {forb, model_valid, model_q, err}); end
        total++; if (forb_cnt !== 8'd1) begin bad++; $display("FAIL forb_cnt got=%0d exp=1", forb_cnt); end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        total++; if ({forb, model_valid} !== 2'b00) begin bad++; $display("FAIL forb_sync got=%b exp=00", {forb, model_valid}); end
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        total++; if ({model_valid, model_q} !== 2'b11) begin bad++; $display("FAIL forb_resync got=%b exp=11", {model_valid, model_q}); end
        total++; if (err_cnt !== 8'd3 || sticky_err !== 1'b1) begin bad++; $display("FAIL forb_keep cnt=%0d sticky=%b exp=3/1", err_cnt, sticky_err); end
    endtask

    task automatic test_clr();
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        total++; if ({err_cnt, forb_cnt} !== 16'h0 || sticky_err !== 1'b0) begin bad++; $display("FAIL clr_cnts cnts=%h sticky=%b exp=0000/0", {err_cnt, forb_cnt}, sticky_err); end
        total++; if ({model_valid, model_q} !== 2'b11) begin bad++; $display("FAIL clr_fsm got=%b exp=11", {model_valid, model_q}); end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            if (i == 2) begin
                total++; if (n_err_cnt !== 2'd3) begin bad++; $display("FAIL sat_reach got=%0d exp=3", n_err_cnt); end
            end
        end
        total++; if (n_err_cnt !== 2'd3 || n_err !== 1'b1) begin bad++; $display("FAIL sat_hold cnt=%0d err=%b exp=3/1", n_err_cnt, n_err); end
        total++; if (err_cnt !== 8'd5) begin bad++; $display("FAIL sat_wide got=%0d exp=5", err_cnt); end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        total++; if (n_err_cnt !== 2'd0 || n_err !== 1'b1 || n_sticky_err !== 1'b0) begin bad++; $display("FAIL sat_clr cnt=%0d err=%b sticky=%b exp=0/1/0", n_err_cnt, n_err, n_sticky_err); end
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        total++; if (forb !== 1'b1 || forb_cnt !== 8'd0 || model_valid !== 1'b0) begin bad++; $display("FAIL forb_clr forb=%b cnt=%0d valid=%b exp=1/0/0", forb, forb_cnt, model_valid); end
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        total++; if (forb !== 1'b1 || forb_cnt !== 8'd1 || model_valid !== 1'b0) begin bad++; $display("FAIL forb_sync2 forb=%b cnt=%0d valid=%b exp=1/1/0", forb, forb_cnt, model_valid); end
    endtask

    task automatic test_async_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        total++; if (err_cnt !== 8'd2 || model_valid !== 1'b1) begin bad++; $display("FAIL ar_setup cnt=%0d valid=%b exp=2/1", err_cnt, model_valid); end
        #2;
        rst = 1'b1;
        #1;
        total++; if ({model_q, model_valid, err, forb, sticky_err} !== 5'b0) begin bad++; $display("FAIL ar_flags got=%b exp=00000", {model_q, model_valid, err, forb, sticky_err}); end
        total++; if ({err_cnt, forb_cnt} !== 16'h0) begin bad++; $display("FAIL ar_cnts got=%h exp=0000", {err_cnt, forb_cnt}); end
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        total++; if (model_valid !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL ar_nosync valid=%b err=%b exp=0/0", model_valid, err); end
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        total++; if ({model_valid, model_q, err} !== 3'b100) begin bad++; $display("FAIL ar_resync got=%b exp=100", {model_valid, model_q, err}); end
    endtask

    initial begin
        test_reset();
        test_sync_track();
        test_mismatch();
        test_forbidden();
        test_clr();
        test_saturate();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
